// File: rtl/fm_diff_demod_if.sv
// rtl/fm_diff_demod_if.sv - sample/DAC signal bundle for the differential FM demodulator
//
// Ports (master = sample source / DAC sink, slave = demodulator):
//   in_valid  : ad_data/ad_otr valid this cycle
//   ad_data   : ADC sample, offset-binary, DW bits
//   ad_otr    : ADC over-range indicator for this sample
//   clr_flags : one-cycle pulse, clears sticky flags
//   out_valid : da_data updated this cycle
//   da_data   : DAC word, OUT_W bits
//   env_out   : unscaled envelope (boxcar mean), DW+1 bits
//   sat_flag  : sticky, output saturated since last clear
//   otr_flag  : sticky, over-range sample masked since last clear
interface fm_diff_demod_if #(
    parameter int DW    = 8,
    parameter int OUT_W = 8
);
    logic             in_valid;
    logic [DW-1:0]    ad_data;
    logic             ad_otr;
    logic             clr_flags;
    logic             out_valid;
    logic [OUT_W-1:0] da_data;
    logic [DW:0]      env_out;
    logic             sat_flag;
    logic             otr_flag;

    modport master (
        output in_valid, ad_data, ad_otr, clr_flags,
        input  out_valid, da_data, env_out, sat_flag, otr_flag
    );

    modport slave (
        input  in_valid, ad_data, ad_otr, clr_flags,
        output out_valid, da_data, env_out, sat_flag, otr_flag
    );
endinterface

// File: rtl/fm_diff_demod.sv
// rtl/fm_diff_demod.sv - differential FM demodulator: offset removal, LAG differentiator, rectifier, boxcar, gain/saturate
//
// Ports:
//   sys_clk : sample-domain clock
//   sys_rst : asynchronous, active-high reset
//   bus     : fm_diff_demod_if.slave (sample in, DAC word out, envelope debug, sticky flags)
//
// Optional macro FM_DCBLOCK_EN: adds a DC-tracking stage after the gain stage,
// centring the output at mid-scale and moving latency from E+4 to E+5.
module fm_diff_demod #(
    parameter int DW       = 8,
    parameter int LAG      = 1,
    parameter int AVG_LOG2 = 4,
    parameter int GAIN_SH  = 4,
    parameter int OUT_W    = 8,
    parameter int DC_SH    = 8
) (
    input logic            sys_clk,
    input logic            sys_rst,
    fm_diff_demod_if.slave bus
);
    localparam int NBUF = 1 << AVG_LOG2;
    localparam int AW   = DW + 1 + AVG_LOG2;
    localparam int PW   = $clog2(LAG + 1);

    // Valid pipeline: bit k means stage k holds a live sample
    logic [3:0]              v_q, v_d;
    logic signed [DW-1:0]    x_q, x_d;
    logic signed [DW-1:0]    dly_q [LAG];
    logic signed [DW-1:0]    dly_d [LAG];
    logic [PW-1:0]           prime_q, prime_d;
    logic signed [DW:0]      d_q, d_d;
    logic [DW:0]             a_q, a_d;
    logic [DW:0]             box_q [NBUF];
    logic [DW:0]             box_d [NBUF];
    logic [AVG_LOG2-1:0]     wp_q, wp_d;
    logic [AW-1:0]           acc_q, acc_d;
    logic                    out_valid_q, out_valid_d;
    logic [OUT_W-1:0]        da_q, da_d;
    logic [DW:0]             env_q, env_d;
    logic                    sat_q, sat_d;
    logic                    otr_q, otr_d;
    logic [DW:0]             env_c;
    logic                    sat_set;

`ifdef FM_DCBLOCK_EN
    // dc carries DC_SH fractional bits; one sign bit above the envelope range
    localparam int DCW = DW + 2 + DC_SH;
    localparam int YW  = DCW + GAIN_SH + 2;
    localparam logic signed [YW-1:0] Y_MAX = YW'((64'd1 << OUT_W) - 64'd1);
    localparam logic signed [YW-1:0] Y_MID = YW'(64'd1 << (OUT_W - 1));

    logic                    v4_q, v4_d;
    logic [DW:0]             envr_q, envr_d;
    logic signed [DCW-1:0]   dc_q, dc_d;
    logic signed [DCW-1:0]   err_c, dc_int_c;
    logic signed [YW-1:0]    y_c;
`else
    localparam int SW = ((DW + 1 + GAIN_SH) > OUT_W ? (DW + 1 + GAIN_SH) : OUT_W) + 1;
    localparam logic [SW-1:0] DA_MAX = SW'((64'd1 << OUT_W) - 64'd1);

    logic [SW-1:0]           s_c;
`endif

    always_comb begin
        v_d         = {v_q[2:0], bus.in_valid};
        x_d         = x_q;
        dly_d       = dly_q;
        prime_d     = prime_q;
        d_d         = d_q;
        a_d         = a_q;
        box_d       = box_q;
        wp_d        = wp_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        da_d        = da_q;
        env_d       = env_q;
        sat_set     = 1'b0;
        env_c       = acc_q[AW-1:AVG_LOG2];

        // S0: offset-binary to two's complement is an MSB flip; an
        // over-range sample keeps the previous accepted value in x_q.
        if (bus.in_valid && !bus.ad_otr) begin
            x_d = {~bus.ad_data[DW-1], bus.ad_data[DW-2:0]};
        end

        // S1: differentiate against the sample LAG accepted samples back
        if (v_q[0]) begin
            dly_d[0] = x_q;
            for (int i = 1; i < LAG; i++) begin
                dly_d[i] = dly_q[i-1];
            end
            if (prime_q < PW'(LAG)) begin
                prime_d = prime_q + PW'(1);
                d_d     = '0;
            end else begin
                d_d = (DW+1)'(x_q) - (DW+1)'(dly_q[LAG-1]);
            end
        end

        // S2: full-wave rectify; |d| <= 2^DW-1 fits unsigned DW+1
        if (v_q[1]) begin
            a_d = d_q[DW] ? $unsigned(-d_q) : $unsigned(d_q);
        end

        // S3: running-sum boxcar, oldest entry leaves as the new one enters
        if (v_q[2]) begin
            acc_d        = acc_q + AW'(a_q) - AW'(box_q[wp_q]);
            box_d[wp_q]  = a_q;
            wp_d         = wp_q + AVG_LOG2'(1);
        end

`ifdef FM_DCBLOCK_EN
        v4_d     = v_q[3];
        envr_d   = envr_q;
        dc_d     = dc_q;
        err_c    = $signed(DCW'(envr_q) << DC_SH) - dc_q;
        dc_int_c = dc_q >>> DC_SH;
        y_c      = $signed(YW'(envr_q)) - YW'(dc_int_c);
        y_c      = (y_c <<< GAIN_SH) + Y_MID;

        // S4: register the mean so the tracker sees a stable envelope
        if (v_q[3]) begin
            envr_d = env_c;
        end

        // S5: subtract the tracked DC, re-centre, clip at both rails
        if (v4_q) begin
            out_valid_d = 1'b1;
            env_d       = envr_q;
            dc_d        = dc_q + (err_c >>> DC_SH);
            if (y_c < 0) begin
                da_d    = '0;
                sat_set = 1'b1;
            end else if (y_c > Y_MAX) begin
                da_d    = Y_MAX[OUT_W-1:0];
                sat_set = 1'b1;
            end else begin
                da_d = y_c[OUT_W-1:0];
            end
        end
`else
        s_c = SW'(env_c) << GAIN_SH;

        // S4: shift gain with saturation at full scale
        if (v_q[3]) begin
            out_valid_d = 1'b1;
            env_d       = env_c;
            if (s_c > DA_MAX) begin
                da_d    = DA_MAX[OUT_W-1:0];
                sat_set = 1'b1;
            end else begin
                da_d = s_c[OUT_W-1:0];
            end
        end
`endif

        // Set wins over a simultaneous clear
        sat_d = (sat_q & ~bus.clr_flags) | sat_set;
        otr_d = (otr_q & ~bus.clr_flags) | (bus.in_valid & bus.ad_otr);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            v_q         <= '0;
            x_q         <= '0;
            for (int i = 0; i < LAG; i++) begin
                dly_q[i] <= '0;
            end
            prime_q     <= '0;
            d_q         <= '0;
            a_q         <= '0;
            for (int i = 0; i < NBUF; i++) begin
                box_q[i] <= '0;
            end
            wp_q        <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            da_q        <= '0;
            env_q       <= '0;
            sat_q       <= 1'b0;
            otr_q       <= 1'b0;
`ifdef FM_DCBLOCK_EN
            v4_q        <= 1'b0;
            envr_q      <= '0;
            dc_q        <= '0;
`endif
        end else begin
            v_q         <= v_d;
            x_q         <= x_d;
            dly_q       <= dly_d;
            prime_q     <= prime_d;
            d_q         <= d_d;
            a_q         <= a_d;
            box_q       <= box_d;
            wp_q        <= wp_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            da_q        <= da_d;
            env_q       <= env_d;
            sat_q       <= sat_d;
            otr_q       <= otr_d;
`ifdef FM_DCBLOCK_EN
            v4_q        <= v4_d;
            envr_q      <= envr_d;
            dc_q        <= dc_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.da_data   = da_q;
    assign bus.env_out   = env_q;
    assign bus.sat_flag  = sat_q;
    assign bus.otr_flag  = otr_q;
endmodule

// File: tb/tb_fm_diff_demod.sv
// tb/tb_fm_diff_demod.sv - self-checking bench for fm_diff_demod (default parameters, FM_DCBLOCK_EN undefined)
module tb_fm_diff_demod;
    localparam int DW    = 8;
    localparam int LAG   = 1;
    localparam int NAVG  = 16;
    localparam int GAIN  = 16;
    localparam int DAMAX = 255;

    logic clk;
    logic rst;

    fm_diff_demod_if #(.DW(DW), .OUT_W(8)) bus ();

    fm_diff_demod dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic over the history of accepted samples
    typedef struct {
        int due;
        int da;
        int env;
        bit sat;
    } exp_t;

    exp_t pend[$];
    int   xs[$];
    int   as_[$];
    int   last_x;
    int   da_m;
    bit   sat_m;
    bit   otr_m;
    int   cyc;
    int   cnt112;

    function automatic void model_reset();
        pend.delete();
        xs.delete();
        as_.delete();
        last_x = 0;
        da_m   = 0;
        sat_m  = 1'b0;
        otr_m  = 1'b0;
    endfunction

    function automatic void model_accept(input int data, input bit otr);
        int x, n, d, a, sum, env, s;
        exp_t e;
        x = otr ? last_x : data - 128;
        last_x = x;
        xs.push_back(x);
        n = xs.size() - 1;
        d = (n < LAG) ? 0 : x - xs[n-LAG];
        a = (d < 0) ? -d : d;
        as_.push_back(a);
        sum = 0;
        for (int i = 0; i < NAVG && i < as_.size(); i++) sum += as_[as_.size()-1-i];
        env = sum / NAVG;
        s   = env * GAIN;
        e.due = cyc + 4;
        e.env = env;
        e.sat = (s > DAMAX);
        e.da  = (s > DAMAX) ? DAMAX : s;
        pend.push_back(e);
    endfunction

    // One clock: drive at posedge+1, sample at the following posedge+1
    task automatic step(input bit v, input int data, input bit otr, input bit clr);
        exp_t e;
        bus.in_valid  = v;
        bus.ad_data   = data[7:0];
        bus.ad_otr    = otr;
        bus.clr_flags = clr;
        @(posedge clk);
        #1;
        cyc++;
        if (clr) begin
            sat_m = 1'b0;
            otr_m = 1'b0;
        end
        if (v) begin
            model_accept(data, otr);
            if (otr) otr_m = 1'b1;
        end
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e = pend.pop_front();
            chk("out_valid", int'(bus.out_valid), 1);
            chk("da_data", int'(bus.da_data), e.da);
            chk("env_out", int'(bus.env_out), e.env);
            if (bus.out_valid && bus.da_data == 8'd112) cnt112++;
            da_m = e.da;
            if (e.sat) sat_m = 1'b1;
        end else begin
            chk("out_valid_idle", int'(bus.out_valid), 0);
            chk("da_hold", int'(bus.da_data), da_m);
        end
        chk("sat_flag", int'(bus.sat_flag), int'(sat_m));
        chk("otr_flag", int'(bus.otr_flag), int'(otr_m));
    endtask

    // Asynchronous reset raised between edges; outputs must clear at once
    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_da_data", int'(bus.da_data), 0);
        chk("rst_env_out", int'(bus.env_out), 0);
        chk("rst_sat_flag", int'(bus.sat_flag), 0);
        chk("rst_otr_flag", int'(bus.otr_flag), 0);
        bus.in_valid  = 1'b0;
        bus.ad_otr    = 1'b0;
        bus.clr_flags = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit       v;
        bit [7:0] data;
        bit       clr;
        bit       exp_ov;
        bit [7:0] exp_da;
        bit       exp_sat;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // Alternating 0/255: 0 (primed), 240, then saturated 255; clr during saturation keeps sat set
        tbl[0] = '{1'b1, 8'd0,   1'b0, 1'b0, 8'd0,   1'b0};
        tbl[1] = '{1'b1, 8'd255, 1'b0, 1'b0, 8'd0,   1'b0};
        tbl[2] = '{1'b1, 8'd0,   1'b0, 1'b0, 8'd0,   1'b0};
        tbl[3] = '{1'b1, 8'd255, 1'b0, 1'b0, 8'd0,   1'b0};
        tbl[4] = '{1'b1, 8'd0,   1'b0, 1'b1, 8'd0,   1'b0};
        tbl[5] = '{1'b1, 8'd255, 1'b0, 1'b1, 8'd240, 1'b0};
        tbl[6] = '{1'b1, 8'd0,   1'b0, 1'b1, 8'd255, 1'b1};
        tbl[7] = '{1'b1, 8'd255, 1'b1, 1'b1, 8'd255, 1'b1};
        tbl[8] = '{1'b1, 8'd0,   1'b0, 1'b1, 8'd255, 1'b1};
        tbl[9] = '{1'b1, 8'd255, 1'b0, 1'b1, 8'd255, 1'b1};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.ad_data   = '0;
        bus.ad_otr    = 1'b0;
        bus.clr_flags = 1'b0;
        cyc           = 0;
        cnt112        = 0;
        model_reset();
        #2;
        chk("por_da_data", int'(bus.da_data), 0);
        chk("por_out_valid", int'(bus.out_valid), 0);
        #10;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            bus.in_valid  = tbl[i].v;
            bus.ad_data   = tbl[i].data;
            bus.ad_otr    = 1'b0;
            bus.clr_flags = tbl[i].clr;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", i), int'(bus.out_valid), int'(tbl[i].exp_ov));
            chk($sformatf("tbl%0d_da_data", i), int'(bus.da_data), int'(tbl[i].exp_da));
            chk($sformatf("tbl%0d_sat_flag", i), int'(bus.sat_flag), int'(tbl[i].exp_sat));
        end
        do_reset();

        // Constant mid-scale: all zero, first output 4 cycles after first sample
        for (int i = 0; i < 12; i++) step(1'b1, 128, 1'b0, 1'b0);
        do_reset();

        // Step 128 -> 255: one a=127 gives 16 outputs of 112
        cnt112 = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 128, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, 255, 1'b0, 1'b0);
        chk("step_count112", cnt112, 16);
        do_reset();

        // Same with a sample every 4th cycle
        cnt112 = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b1, (i < 20) ? 128 : 255, 1'b0, 1'b0);
            for (int j = 0; j < 3; j++) step(1'b0, 0, 1'b0, 1'b0);
        end
        chk("sparse_count112", cnt112, 16);
        do_reset();

        // Over-range sample is masked, flag sticks until cleared
        for (int i = 0; i < 10; i++) step(1'b1, 128, 1'b0, 1'b0);
        step(1'b1, 0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 128, 1'b0, 1'b0);
        step(1'b1, 128, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 128, 1'b0, 1'b0);
        do_reset();

        // Reset in the middle of saturation, then prime re-arm with a large first sample
        for (int i = 0; i < 9; i++) step(1'b1, (i % 2) ? 255 : 0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 128, 1'b0, 1'b0);
        do_reset();

        // Random: full-range then small-amplitude, with bubbles, over-range and clears
        for (int i = 0; i < 1600; i++) begin
            int  data;
            bit  v, otr, clr;
            v   = ($urandom_range(0, 3) != 0);
            otr = ($urandom_range(0, 15) == 0);
            clr = ($urandom_range(0, 31) == 0);
            if (i < 800) data = int'($urandom_range(0, 255));
            else         data = 128 + int'($urandom_range(0, 40)) - 20;
            step(v, data, otr, clr);
            if (i == 800) do_reset();
        end
        for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b0, 1'b0);
        chk("pending_drained", pend.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
